param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 32, data width in bits, >=1.
- DEPTH, 16, memory entries, power of two, >=2.
- OUT_REG, 0, 0 = show-ahead output straight from memory; 1 = extra registered output stage.
- AFULL_TH, DEPTH-2, almost_full threshold, 1..DEPTH.
- AEMPTY_TH, 1, almost_empty threshold, 0..DEPTH-1.
- LVL_W, clog2(DEPTH+2), width of level_o.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, single clock; all state changes on its rising edge.
- rst_i, in, 1, reset, asynchronous, active-high.
- flush_i, in, 1, synchronous clear.
- wr_data_i, in, DATA_W, write data.
- wr_vld_i, in, 1, write valid.
- wr_rdy_o, out, 1, write ready.
- rd_data_o, out, DATA_W, read data.
- rd_vld_o, out, 1, read valid.
- rd_rdy_i, in, 1, read ready.
- level_o, out, LVL_W, entries held (memory plus output register).
- almost_full_o, out, 1, level_o >= AFULL_TH.
- almost_empty_o, out, 1, level_o <= AEMPTY_TH.
- ovf_o, out, 1, one-cycle pulse on a refused write.

Function
REQ-003 Read and write pointers SHALL be clog2(DEPTH)+1 bits and wrap naturally from all-ones to zero.
- empty: pointers equal.
- full: MSBs differ and remaining bits are equal.
REQ-004 wr_rdy_o SHALL equal !full, decoded from registered pointers only.
- A write transfer occurs when wr_vld_i && wr_rdy_o at a rising edge.
- The transfer stores wr_data_i at the write address and increments the write pointer.
REQ-005 OUT_REG=0 (show-ahead) timing:
- rd_vld_o SHALL equal !empty.
- rd_data_o SHALL equal mem[read address].
- A read transfer occurs when rd_vld_o && rd_rdy_i at a rising edge and increments the read pointer.
- A word written at edge N is visible on rd_vld_o/rd_data_o immediately after edge N (latency 1).
REQ-006 OUT_REG=1 timing:
- The output register SHALL load mem[read address] and advance the read pointer at an edge where memory is non-empty and (the register is empty or is being read).
- rd_vld_o is the register's valid bit.
- Write-to-rd_vld_o latency is 2 edges.
- Back-to-back reads SHALL sustain one transfer per cycle.
REQ-007 rd_data_o and rd_vld_o SHALL stay stable while rd_vld_o=1 and rd_rdy_i=0.
REQ-008 Simultaneous read and write SHALL leave level_o unchanged.
- When full, a read in the same cycle does not enable the write: wr_rdy_o is already 0.
- When empty (OUT_REG=0), only the write takes effect.
REQ-009 level_o SHALL be a registered count: +1 per write transfer, -1 per read transfer.
- It equals entries in memory plus the output register valid bit.
- Maximum is DEPTH+OUT_REG.
REQ-010 almost_full_o and almost_empty_o SHALL be combinational compares on registered level_o.
REQ-011 ovf_o SHALL be a registered pulse, high for exactly the cycle after an edge with wr_vld_i=1 and full=1.
- The refused data is not stored.
REQ-012 flush_i=1 at an edge SHALL have priority over all transfers in that cycle.
- Both pointers go to 0, the output register valid clears, level_o goes to 0, and ovf_o goes to 0.
- Memory contents are not cleared.
REQ-013 Memory SHALL be unreset storage.
- rd_data_o is don't-care while rd_vld_o=0.

Reset
REQ-014 While rst_i=1, regardless of clock, the block SHALL hold the following state:
- Pointers 0.
- level_o=0.
- rd_vld_o=0.
- wr_rdy_o=1.
- almost_empty_o=1.
- almost_full_o=0.
- ovf_o=0.
- Output register data 0.
REQ-015 Deasserting rst_i mid-stream SHALL resume from the empty state.
- No transfer occurs on an edge while rst_i=1.

Verification
REQ-016 Fill/drain (DEPTH=16, OUT_REG=0): write 0..15 with rd_rdy_i=0.
- wr_rdy_o falls after the 16th write; level_o=16; almost_full_o=1 from level 14.
- Draining returns 0..15 in order; almost_empty_o=1 at level<=1.
REQ-017 Overflow: with the FIFO full, hold wr_vld_i=1 with data 0xDEAD for 3 cycles.
- ovf_o pulses each following cycle; level_o stays 16.
- 0xDEAD never appears on read.
REQ-018 Simultaneous traffic: at level 5, do 20 cycles of write+read each edge.
- level_o stays 5; data order is preserved across pointer wrap.
REQ-019 OUT_REG=1: write 0xA5 into an empty FIFO at edge N.
- rd_vld_o=1 after edge N+1 with rd_data_o=0xA5.
- Streaming 32 words with rd_rdy_i=1 yields one word per cycle.
REQ-020 Flush with level 7 and simultaneous wr/rd handshakes.
- After the edge: level_o=0, rd_vld_o=0, wr_rdy_o=1.
- The next written word is the next word read.
REQ-021 Assert rst_i asynchronously between edges at level 9.
- Outputs reach reset values immediately, without waiting for a clock edge.
- After release, the first written word is the first word read.

Source files
------------

// File: rtl/param_fifo.sv
// Synchronous FIFO with show-ahead or registered output, level tracking,
// almost-full/empty flags and an overflow pulse on refused writes.
module param_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int OUT_REG   = 0,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 1,
  parameter int LVL_W     = $clog2(DEPTH + 2)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_vld_i,
  output logic              wr_rdy_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_vld_o,
  input  logic              rd_rdy_i,
  output logic [LVL_W-1:0]  level_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;
  logic              ovf_reg;

  logic mem_empty;
  logic mem_full;
  logic wr_fire;
  logic mem_pop;
  logic rd_fire;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign mem_empty = (wr_ptr_reg == rd_ptr_reg);
  assign mem_full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign wr_rdy_o  = !mem_full;
  assign wr_fire   = wr_vld_i && !mem_full;

  // Storage is left unreset; a write into the free slot during flush is harmless.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (mem_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      ovf_reg <= wr_vld_i && mem_full;
      // Level tracks external transfers only; a memory-to-register move is neutral.
      if (wr_fire && !rd_fire) begin
        level_reg <= level_reg + LVL_W'(1);
      end else if (!wr_fire && rd_fire) begin
        level_reg <= level_reg - LVL_W'(1);
      end
    end
  end

  generate
    if (OUT_REG == 0) begin : g_show_ahead
      assign mem_pop   = !mem_empty && rd_rdy_i;
      assign rd_fire   = mem_pop;
      assign rd_vld_o  = !mem_empty;
      assign rd_data_o = mem[rd_ptr_reg[AW-1:0]];
    end else begin : g_out_reg
      logic              out_vld_reg;
      logic [DATA_W-1:0] out_data_reg;

      assign rd_fire = out_vld_reg && rd_rdy_i;
      // Refill whenever the register is empty or being drained this cycle.
      assign mem_pop = !mem_empty && (!out_vld_reg || rd_rdy_i);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          out_vld_reg  <= 1'b0;
          out_data_reg <= '0;
        end else if (flush_i) begin
          out_vld_reg <= 1'b0;
        end else if (mem_pop) begin
          out_vld_reg  <= 1'b1;
          out_data_reg <= mem[rd_ptr_reg[AW-1:0]];
        end else if (rd_fire) begin
          out_vld_reg <= 1'b0;
        end
      end

      assign rd_vld_o  = out_vld_reg;
      assign rd_data_o = out_data_reg;
    end
  endgenerate

  assign level_o        = level_reg;
  assign almost_full_o  = (level_reg >= LVL_W'(AFULL_TH));
  assign almost_empty_o = (level_reg <= LVL_W'(AEMPTY_TH));
  assign ovf_o          = ovf_reg;

endmodule

// File: tb/tb_param_fifo.sv
// Drives a show-ahead and a registered-output FIFO with shared stimulus and
// checks both against queue-based models every cycle.
module tb_param_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AFTH  = DEPTH - 2;
  localparam int AETH  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_vld = 1'b0;
  logic          rd_rdy = 1'b0;

  logic          wr_rdy0, rd_vld0, af0, ae0, ovf0;
  logic [DW-1:0] rd_data0;
  logic [4:0]    level0;
  logic          wr_rdy1, rd_vld1, af1, ae1, ovf1;
  logic [DW-1:0] rd_data1;
  logic [4:0]    level1;

  int n_cmp = 0;
  int n_err = 0;

  param_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .OUT_REG(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .wr_data_i(wr_data), .wr_vld_i(wr_vld), .wr_rdy_o(wr_rdy0),
    .rd_data_o(rd_data0), .rd_vld_o(rd_vld0), .rd_rdy_i(rd_rdy),
    .level_o(level0), .almost_full_o(af0), .almost_empty_o(ae0), .ovf_o(ovf0)
  );

  param_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .OUT_REG(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .wr_data_i(wr_data), .wr_vld_i(wr_vld), .wr_rdy_o(wr_rdy1),
    .rd_data_o(rd_data1), .rd_vld_o(rd_vld1), .rd_rdy_i(rd_rdy),
    .level_o(level1), .almost_full_o(af1), .almost_empty_o(ae1), .ovf_o(ovf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: q0 holds every entry of the show-ahead FIFO; q1 holds the memory of
  // the registered FIFO and (ov1, od1) its output slot.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit            ov1;
  logic [DW-1:0] od1;
  bit            ovf_m0, ovf_m1;

  task automatic model_clear();
    q0.delete();
    q1.delete();
    ov1 = 1'b0;
    od1 = '0;
    ovf_m0 = 1'b0;
    ovf_m1 = 1'b0;
  endtask

  task automatic model_step();
    bit r0, w0, r1, w1;
    if (flush) begin
      q0.delete();
      q1.delete();
      ov1 = 1'b0;
      ovf_m0 = 1'b0;
      ovf_m1 = 1'b0;
      return;
    end
    r0 = (q0.size() > 0) && rd_rdy;
    w0 = wr_vld && (q0.size() < DEPTH);
    ovf_m0 = wr_vld && (q0.size() == DEPTH);
    if (r0) void'(q0.pop_front());
    if (w0) q0.push_back(wr_data);

    r1 = ov1 && rd_rdy;
    w1 = wr_vld && (q1.size() < DEPTH);
    ovf_m1 = wr_vld && (q1.size() == DEPTH);
    if ((q1.size() > 0) && (!ov1 || rd_rdy)) begin
      od1 = q1.pop_front();
      ov1 = 1'b1;
    end else if (r1) begin
      ov1 = 1'b0;
    end
    if (w1) q1.push_back(wr_data);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_clear();
    else model_step();
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    int l0, l1;
    l0 = q0.size();
    l1 = q1.size() + (ov1 ? 1 : 0);
    chk("level0", 32'(level0), 32'(l0));
    chk("rd_vld0", 32'(rd_vld0), 32'(l0 > 0));
    if (l0 > 0) chk("rd_data0", 32'(rd_data0), 32'(q0[0]));
    chk("wr_rdy0", 32'(wr_rdy0), 32'(q0.size() < DEPTH));
    chk("afull0", 32'(af0), 32'(l0 >= AFTH));
    chk("aempty0", 32'(ae0), 32'(l0 <= AETH));
    chk("ovf0", 32'(ovf0), 32'(ovf_m0));
    chk("level1", 32'(level1), 32'(l1));
    chk("rd_vld1", 32'(rd_vld1), 32'(ov1));
    if (ov1) chk("rd_data1", 32'(rd_data1), 32'(od1));
    chk("wr_rdy1", 32'(wr_rdy1), 32'(q1.size() < DEPTH));
    chk("afull1", 32'(af1), 32'(l1 >= AFTH));
    chk("aempty1", 32'(ae1), 32'(l1 <= AETH));
    chk("ovf1", 32'(ovf1), 32'(ovf_m1));
  end

  task automatic idle();
    wr_vld = 1'b0;
    rd_rdy = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    idle();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_level0", 32'(level0), 0);
    chk("rst_wr_rdy0", 32'(wr_rdy0), 1);
    chk("rst_rd_vld0", 32'(rd_vld0), 0);
    chk("rst_ae0", 32'(ae0), 1);
    chk("rst_af0", 32'(af0), 0);
    chk("rst_rd_data1", 32'(rd_data1), 0);
    rst = 1'b0;
    $display("step: reset released");

    // Fill 0..15 without reading
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("fill_level", 32'(level0), 32'(i));
      chk("fill_af", 32'(af0), 32'(i >= 14));
      chk("fill_ae", 32'(ae0), 32'(i <= 1));
      wr_vld = 1'b1;
      wr_data = DW'(i);
    end
    @(negedge clk);
    wr_vld = 1'b0;
    chk("full_level", 32'(level0), 16);
    chk("full_wr_rdy", 32'(wr_rdy0), 0);
    chk("full_af", 32'(af0), 1);
    chk("model_full_lvl", 32'(q0.size()), 16);
    $display("step: filled 16 words, level=%0d", level0);

    // Overflow: three refused writes of 0xDEAD
    wr_vld = 1'b1;
    wr_data = 16'hDEAD;
    repeat (3) begin
      @(negedge clk);
      chk("ovf_pulse", 32'(ovf0), 1);
      chk("ovf_level", 32'(level0), 16);
    end
    wr_vld = 1'b0;
    @(negedge clk);
    chk("ovf_clear", 32'(ovf0), 0);
    $display("step: overflow checked");

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      chk("drain_vld", 32'(rd_vld0), 1);
      chk("drain_data", 32'(rd_data0), 32'(i));
      chk("drain_ae", 32'(ae0), 32'((16 - i) <= 1));
      rd_rdy = 1'b1;
      @(negedge clk);
    end
    rd_rdy = 1'b0;
    chk("drained_vld", 32'(rd_vld0), 0);
    chk("drained_level", 32'(level0), 0);
    $display("step: drained 16 words");

    // Level 5 then 20 cycles of simultaneous traffic across pointer wrap
    do_flush();
    for (int i = 0; i < 5; i++) begin
      wr_vld = 1'b1;
      wr_data = DW'(100 + i);
      @(negedge clk);
    end
    for (int k = 0; k < 20; k++) begin
      chk("simul_level", 32'(level0), 5);
      chk("simul_data", 32'(rd_data0), (k < 5) ? 32'(100 + k) : 32'(200 + k - 5));
      wr_vld = 1'b1;
      rd_rdy = 1'b1;
      wr_data = DW'(200 + k);
      @(negedge clk);
    end
    idle();
    $display("step: simultaneous traffic done, level=%0d", level0);

    // Registered output latency and streaming
    do_flush();
    wr_vld = 1'b1;
    wr_data = 16'h00A5;
    @(negedge clk);
    wr_vld = 1'b0;
    chk("lat_vld0", 32'(rd_vld0), 1);
    chk("lat_vld1_early", 32'(rd_vld1), 0);
    @(negedge clk);
    chk("lat_vld1", 32'(rd_vld1), 1);
    chk("lat_data1", 32'(rd_data1), 32'h00A5);
    do_flush();
    for (int k = 0; k < 34; k++) begin
      if (k >= 2) begin
        chk("stream_vld1", 32'(rd_vld1), 1);
        chk("stream_data1", 32'(rd_data1), 32'(300 + k - 2));
      end
      wr_vld = (k < 32);
      wr_data = DW'(300 + k);
      rd_rdy = 1'b1;
      @(negedge clk);
    end
    idle();
    chk("stream_end_vld1", 32'(rd_vld1), 0);
    $display("step: streamed 32 words through registered output");

    // Flush at level 7 with simultaneous handshakes
    for (int i = 0; i < 7; i++) begin
      wr_vld = 1'b1;
      wr_data = DW'(400 + i);
      @(negedge clk);
    end
    chk("pre_flush_level", 32'(level0), 7);
    wr_vld = 1'b1;
    rd_rdy = 1'b1;
    flush = 1'b1;
    wr_data = 16'h1234;
    @(negedge clk);
    idle();
    chk("flush_level0", 32'(level0), 0);
    chk("flush_vld0", 32'(rd_vld0), 0);
    chk("flush_wr_rdy0", 32'(wr_rdy0), 1);
    chk("flush_level1", 32'(level1), 0);
    chk("flush_vld1", 32'(rd_vld1), 0);
    wr_vld = 1'b1;
    wr_data = 16'h0077;
    @(negedge clk);
    wr_vld = 1'b0;
    chk("post_flush_data", 32'(rd_data0), 32'h0077);
    $display("step: flush at level 7 checked");

    // Asynchronous reset between edges at level 9
    do_flush();
    for (int i = 0; i < 9; i++) begin
      wr_vld = 1'b1;
      wr_data = DW'(500 + i);
      @(negedge clk);
    end
    wr_vld = 1'b0;
    chk("pre_rst_level", 32'(level0), 9);
    #2 rst = 1'b1;
    #1;
    chk("arst_level0", 32'(level0), 0);
    chk("arst_vld0", 32'(rd_vld0), 0);
    chk("arst_wr_rdy0", 32'(wr_rdy0), 1);
    chk("arst_ae0", 32'(ae0), 1);
    chk("arst_af0", 32'(af0), 0);
    chk("arst_level1", 32'(level1), 0);
    chk("arst_vld1", 32'(rd_vld1), 0);
    chk("arst_data1", 32'(rd_data1), 0);
    @(negedge clk);
    rst = 1'b0;
    wr_vld = 1'b1;
    wr_data = 16'h0099;
    @(negedge clk);
    wr_vld = 1'b0;
    chk("post_rst_data", 32'(rd_data0), 32'h0099);
    $display("step: async reset at level 9 checked");

    // Randomized traffic with occasional flush and async reset pulses
    for (int b = 0; b < 4; b++) begin
      int pw, pr;
      pw = (b == 0) ? 70 : (b == 1) ? 30 : (b == 2) ? 50 : 90;
      pr = (b == 0) ? 30 : (b == 1) ? 70 : (b == 2) ? 50 : 90;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        wr_vld  = ($urandom_range(0, 99) < pw);
        rd_rdy  = ($urandom_range(0, 99) < pr);
        wr_data = DW'($urandom);
        flush   = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 399) == 0) begin
          #2 rst = 1'b1;
          #1 rst = 1'b0;
        end
      end
      $display("step: random block %0d done (wr %0d%%, rd %0d%%)", b, pw, pr);
    end
    @(negedge clk);
    idle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
